// File: rtl/addr_cal_pkg.sv
// Shared types for the sprite address calculator: packed descriptor layouts
// and the signed coordinate type wide enough to hold off-screen origins.
package addr_cal_pkg;

    typedef logic signed [11:0] coord_t;

    typedef struct packed {
        logic [15:0] base_addr;
        logic [15:0] src_w;
        logic [15:0] src_h;
        logic [15:0] disp_w;
        logic [15:0] disp_h;
    } pattern_info_t;

    typedef struct packed {
        logic       visible;
        logic       hflip;
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] shift;
    } sprite_info_t;

endpackage

// File: rtl/addr_cal_axis.sv
// One screen axis: sprite origin, offset of the current pixel from it,
// display-box range check and texture wrap by power-of-two mask.
module addr_cal_axis
    import addr_cal_pkg::*;
(
    input  logic [9:0]  pos_i,
    input  logic [9:0]  shift_i,
    input  logic [9:0]  screen_i,
    input  logic [15:0] disp_i,
    input  logic [15:0] src_i,
    output logic        inside_o,
    output logic [15:0] idx_o
);

    coord_t origin;
    coord_t delta;

    always_comb begin
        // Widen before subtracting so origins left of / above the screen go negative.
        origin   = coord_t'({2'b00, pos_i}) - coord_t'({2'b00, shift_i});
        delta    = coord_t'({2'b00, screen_i}) - origin;
        inside_o = !delta[11] && ({4'b0000, delta} < disp_i);
        idx_o    = {4'b0000, delta} & (src_i - 16'd1);
    end

endmodule

// File: rtl/addr_cal.sv
// Per-sprite pixel address generator: two axis units feed a multiply-add,
// and the result is registered with one cycle of latency.
module addr_cal
    import addr_cal_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [79:0] pattern_info,
    input  logic [31:0] sprite_info,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [15:0] addr_output,
    output logic        valid
);

    pattern_info_t pat;
    sprite_info_t  spr;
    logic          inside_h, inside_v;
    logic [15:0]   col, row, col_f;
    logic          valid_d, valid_q;
    logic [15:0]   addr_d, addr_q;

    assign pat = pattern_info_t'(pattern_info);
    assign spr = sprite_info_t'(sprite_info);

    addr_cal_axis u_axis_h (
        .pos_i    (spr.x),
        .shift_i  (spr.shift),
        .screen_i (hcount),
        .disp_i   (pat.disp_w),
        .src_i    (pat.src_w),
        .inside_o (inside_h),
        .idx_o    (col)
    );

    addr_cal_axis u_axis_v (
        .pos_i    (spr.y),
        .shift_i  (10'd0),
        .screen_i (vcount),
        .disp_i   (pat.disp_h),
        .src_i    (pat.src_h),
        .inside_o (inside_v),
        .idx_o    (row)
    );

    always_comb begin
        col_f   = spr.hflip ? ((pat.src_w - 16'd1) - col) : col;
        valid_d = spr.visible && inside_h && inside_v;
        addr_d  = valid_d ? (pat.base_addr + row * pat.src_w + col_f) : 16'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= 16'd0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign valid       = valid_q;
    assign addr_output = addr_q;

endmodule

// File: tb/tb_addr_cal.sv
// Self-checking bench for addr_cal: directed vector table, reset and latency
// sequences, then randomized stimulus against an arithmetic reference model.
module tb_addr_cal;

    logic        clk = 1'b0;
    logic        reset;
    logic [79:0] pattern_info;
    logic [31:0] sprite_info;
    logic [9:0]  hcount, vcount;
    logic [15:0] addr_output;
    logic        valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [79:0] pat;
        logic [31:0] spr;
        int          h;
        int          v;
        logic        exp_valid;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    addr_cal dut (
        .clk          (clk),
        .reset        (reset),
        .pattern_info (pattern_info),
        .sprite_info  (sprite_info),
        .hcount       (hcount),
        .vcount       (vcount),
        .addr_output  (addr_output),
        .valid        (valid)
    );

    function automatic logic [79:0] mk_pat(int base, int sw, int sh, int dw, int dh);
        logic [15:0] b, a, c, d, e;
        b = 16'(base); a = 16'(sw); c = 16'(sh); d = 16'(dw); e = 16'(dh);
        return {b, a, c, d, e};
    endfunction

    function automatic logic [31:0] mk_spr(bit vis, bit hf, int x, int y, int sh);
        logic [9:0] xx, yy, ss;
        xx = 10'(x); yy = 10'(y); ss = 10'(sh);
        return {vis, hf, xx, yy, ss};
    endfunction

    // Reference model from the geometric definition, using integer arithmetic.
    function automatic void model(input logic [79:0] p, input logic [31:0] s,
                                  input int h, input int v,
                                  output logic ev, output logic [15:0] ea);
        int base, sw, shh, dw, dh, x, y, sft, dx, dy, row, col, a;
        bit vis, hf;
        base = int'(p[79:64]); sw = int'(p[63:48]); shh = int'(p[47:32]);
        dw = int'(p[31:16]); dh = int'(p[15:0]);
        vis = s[31]; hf = s[30];
        x = int'(s[29:20]); y = int'(s[19:10]); sft = int'(s[9:0]);
        dx = h - (x - sft);
        dy = v - y;
        ev = vis && dx >= 0 && dx < dw && dy >= 0 && dy < dh;
        ea = 16'd0;
        if (ev) begin
            row = dy % shh;
            col = dx % sw;
            if (hf) col = sw - 1 - col;
            a = (base + row * sw + col) % 65536;
            ea = 16'(a);
        end
    endfunction

    task automatic drive(input logic [79:0] p, input logic [31:0] s, input int h, input int v);
        pattern_info = p;
        sprite_info  = s;
        hcount       = 10'(h);
        vcount       = 10'(v);
    endtask

    task automatic check(input string name, input logic ev, input logic [15:0] ea);
        checks++;
        if (valid !== ev || addr_output !== ea) begin
            errors++;
            $display("FAIL %s: got valid=%0b addr=%0d, expected valid=%0b addr=%0d",
                     name, valid, addr_output, ev, ea);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [79:0] p0, p;
        logic [31:0] s;
        logic        ev;
        logic [15:0] ea;
        int          h, v, x, y, sft, sw, sh;

        p0 = mk_pat(0, 32, 16, 32, 16);
        vecs.push_back('{"basic",      p0, mk_spr(1,0,100,50,0),   105, 52,  1'b1, 16'd69});
        vecs.push_back('{"hflip",      p0, mk_spr(1,1,100,50,0),   105, 52,  1'b1, 16'd90});
        vecs.push_back('{"shift",      p0, mk_spr(1,0,100,50,20),  85,  52,  1'b1, 16'd69});
        vecs.push_back('{"vrepeat",    mk_pat(544,32,1,32,128), mk_spr(1,0,200,100,0), 210, 220, 1'b1, 16'd554});
        vecs.push_back('{"dx_eq_w",    p0, mk_spr(1,0,100,50,0),   132, 52,  1'b0, 16'd0});
        vecs.push_back('{"above",      p0, mk_spr(1,0,100,50,0),   105, 49,  1'b0, 16'd0});
        vecs.push_back('{"invisible",  p0, mk_spr(0,0,100,50,0),   105, 52,  1'b0, 16'd0});
        vecs.push_back('{"disp_w0",    mk_pat(0,32,16,0,16), mk_spr(1,0,100,50,0), 105, 52, 1'b0, 16'd0});
        vecs.push_back('{"neg_origin", p0, mk_spr(1,0,10,0,20),    5,   0,   1'b1, 16'd15});
        vecs.push_back('{"no_vwrap",   p0, mk_spr(1,0,100,1020,0), 105, 2,   1'b0, 16'd0});
        vecs.push_back('{"corner",     p0, mk_spr(1,0,100,50,0),   131, 65,  1'b1, 16'd511});
        vecs.push_back('{"right_edge", p0, mk_spr(1,0,1020,0,0),   1023, 0,  1'b1, 16'd3});
        vecs.push_back('{"no_hwrap",   p0, mk_spr(1,0,1020,0,0),   2,   0,   1'b0, 16'd0});
        vecs.push_back('{"base_wrap",  mk_pat(16'hFFF0,32,16,32,16), mk_spr(1,0,100,50,0), 105, 52, 1'b1, 16'd53});

        reset = 1'b1;
        drive(p0, mk_spr(1,0,100,50,0), 105, 52);
        step();
        check("reset_state", 1'b0, 16'd0);
        step();
        check("reset_priority", 1'b0, 16'd0);
        reset = 1'b0;
        step();
        check("first_after_reset", 1'b1, 16'd69);

        foreach (vecs[i]) begin
            drive(vecs[i].pat, vecs[i].spr, vecs[i].h, vecs[i].v);
            step();
            check(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_addr);
        end

        // Output must hold the old result until the next edge.
        drive(p0, mk_spr(1,0,100,50,0), 105, 52);
        step();
        drive(p0, mk_spr(1,1,100,50,0), 105, 52);
        #2;
        check("latency_hold", 1'b1, 16'd69);
        step();
        check("latency_update", 1'b1, 16'd90);

        // Reset while valid, then recovery one cycle after release.
        reset = 1'b1;
        step();
        check("reset_clears", 1'b0, 16'd0);
        reset = 1'b0;
        step();
        check("reset_recover", 1'b1, 16'd90);

        for (int n = 0; n < 300; n++) begin
            sw  = 1 << $urandom_range(0, 9);
            sh  = 1 << $urandom_range(0, 9);
            p   = mk_pat(int'($urandom_range(0, 65535)), sw, sh,
                         int'($urandom_range(0, 80)), int'($urandom_range(0, 80)));
            x   = int'($urandom_range(0, 1023));
            y   = int'($urandom_range(0, 1023));
            sft = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 40));
            s   = mk_spr(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1, x, y, sft);
            h   = (x - sft + int'($urandom_range(0, 90)) - 5) & 1023;
            v   = (y + int'($urandom_range(0, 90)) - 5) & 1023;
            drive(p, s, h, v);
            model(p, s, h, v, ev, ea);
            step();
            check("random", ev, ea);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
